robot_nav_fsm: RTL

ROBOT_NAV_FSM -- requirements
Module: robot_nav_fsm

---
 rtl/robot_nav_pkg.sv | 56 +++++
 rtl/sensor_debounce.sv | 52 +++++
 rtl/robot_nav_fsm.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/robot_nav_pkg.sv
`default_nettype none
// ============================================================================
// Module      : robot_nav_pkg
// Description : State encodings, H-bridge drive codes and the sensor decision
//               table shared by the robot navigation controller.
// Revision    : 1.0 - initial release
// ============================================================================
package robot_nav_pkg;

    typedef enum logic [2:0] {
        ST_STANDBY = 3'd0,
        ST_FORWARD = 3'd1,
        ST_TURN_R  = 3'd2,
        ST_TURN_L  = 3'd3,
        ST_REVERSE = 3'd4
    } nav_state_t;

    // Drive codes packed as {a_fwd, a_rev, b_fwd, b_rev}
    localparam logic [3:0] c_MOT_OFF    = 4'b0000;
    localparam logic [3:0] c_MOT_FWD    = 4'b1010;
    localparam logic [3:0] c_MOT_TURN_R = 4'b1001;
    localparam logic [3:0] c_MOT_TURN_L = 4'b0110;
    localparam logic [3:0] c_MOT_REV    = 4'b0101;

    // Drive code for a state; never sets fwd and rev of one motor together
    function automatic logic [3:0] motor_code(input nav_state_t st);
        logic [3:0] code;
        code = c_MOT_OFF;
        case (st)
            ST_FORWARD: code = c_MOT_FWD;
            ST_TURN_R:  code = c_MOT_TURN_R;
            ST_TURN_L:  code = c_MOT_TURN_L;
            ST_REVERSE: code = c_MOT_REV;
            default:    code = c_MOT_OFF;
        endcase
        return code;
    endfunction

    // Obstacle decision table, evaluated in priority order
    function automatic nav_state_t nav_decide(input logic f, input logic l, input logic r);
        nav_state_t st;
        if (f && l && r)
            st = ST_REVERSE;
        else if (l && !r)
            st = ST_TURN_R;
        else if (!l && r)
            st = ST_TURN_L;
        else if (!f)
            st = ST_FORWARD;
        else
            st = ST_TURN_R;
        return st;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sensor_debounce.sv
`default_nettype none
// ============================================================================
// Module      : sensor_debounce
// Description : Two-flop synchroniser followed by a consecutive-cycle
//               debounce filter for one asynchronous sensor input.
// Revision    : 1.0 - initial release
// ============================================================================
module sensor_debounce #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_raw,
    output logic o_filt
);

    localparam int              c_CW   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(DEB_CYCLES - 1);

    logic            r_sync1;
    logic            r_sync2;
    logic            r_filt;
    logic [c_CW-1:0] r_cnt;

    // Synchronise the raw input, then accept a new level only after it has
    // disagreed with the filtered value for DEB_CYCLES cycles in a row
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_filt  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            if (r_sync2 != r_filt) begin
                if (r_cnt == c_LAST) begin
                    r_filt <= r_sync2;
                    r_cnt  <= '0;
                end else begin
                    r_cnt <= r_cnt + c_CW'(1);
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_filt = r_filt;

endmodule
`default_nettype wire

// File: rtl/robot_nav_fsm.sv
`default_nettype none
// ============================================================================
// Module      : robot_nav_fsm
// Description : Obstacle-avoiding navigation controller: debounced sensors
//               drive a five-state FSM whose state selects PWM-gated H-bridge
//               drives, with a timed reverse escape and a turn-stall guard.
// Revision    : 1.0 - initial release
// ============================================================================
module robot_nav_fsm
    import robot_nav_pkg::*;
#(
    parameter int DEB_CYCLES = 4,
    parameter int PWM_W      = 8,
    parameter int REV_CYCLES = 1000,
    parameter int TURN_MAX   = 100000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             sensor_f,
    input  logic             sensor_l,
    input  logic             sensor_r,
    input  logic [PWM_W-1:0] duty,
    output logic             motor_a_fwd,
    output logic             motor_a_rev,
    output logic             motor_b_fwd,
    output logic             motor_b_rev,
    output logic [2:0]       state_out,
    output logic             stall
);

    localparam int                c_REV_W     = $clog2(REV_CYCLES + 1);
    localparam int                c_TURN_W    = $clog2(TURN_MAX + 1);
    localparam logic [c_REV_W-1:0]  c_REV_LAST  = c_REV_W'(REV_CYCLES - 1);
    localparam logic [c_TURN_W-1:0] c_TURN_LAST = c_TURN_W'(TURN_MAX - 1);

    logic                w_filt_f;
    logic                w_filt_l;
    logic                w_filt_r;
    nav_state_t          r_state;
    nav_state_t          w_next;
    logic                r_stall;
    logic                w_stall_next;
    logic [c_REV_W-1:0]  r_rev_cnt;
    logic [c_TURN_W-1:0] r_turn_cnt;
    logic [PWM_W-1:0]    r_pwm_cnt;
    logic [3:0]          r_motor;
    logic                w_in_turn;
    logic                w_next_turn;
    logic                w_rev_done;
    logic                w_turn_timeout;
    logic                w_pwm_on;

    sensor_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_f (
        .clk(clk), .reset(reset), .i_raw(sensor_f), .o_filt(w_filt_f)
    );
    sensor_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_l (
        .clk(clk), .reset(reset), .i_raw(sensor_l), .o_filt(w_filt_l)
    );
    sensor_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_r (
        .clk(clk), .reset(reset), .i_raw(sensor_r), .o_filt(w_filt_r)
    );

    assign w_in_turn      = (r_state == ST_TURN_R) || (r_state == ST_TURN_L);
    assign w_next_turn    = (w_next == ST_TURN_R) || (w_next == ST_TURN_L);
    assign w_rev_done     = (r_rev_cnt == c_REV_LAST);
    assign w_turn_timeout = w_in_turn && (r_turn_cnt == c_TURN_LAST);
    assign w_pwm_on       = (r_pwm_cnt < duty);

    // Next-state and stall decision; enable low overrides everything
    always_comb begin
        w_next       = ST_STANDBY;
        w_stall_next = r_stall;
        if (!enable) begin
            w_next       = ST_STANDBY;
            w_stall_next = 1'b0;
        end else if (r_stall) begin
            w_next = ST_STANDBY;
        end else begin
            case (r_state)
                ST_STANDBY, ST_FORWARD: begin
                    w_next = nav_decide(w_filt_f, w_filt_l, w_filt_r);
                end
                ST_TURN_R, ST_TURN_L: begin
                    if (w_turn_timeout) begin
                        w_next       = ST_STANDBY;
                        w_stall_next = 1'b1;
                    end else begin
                        w_next = nav_decide(w_filt_f, w_filt_l, w_filt_r);
                    end
                end
                ST_REVERSE: begin
                    w_next = w_rev_done ? ST_TURN_R : ST_REVERSE;
                end
                default: begin
                    w_next = ST_STANDBY;
                end
            endcase
        end
    end

    // State and sticky stall registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_STANDBY;
            r_stall <= 1'b0;
        end else begin
            r_state <= w_next;
            r_stall <= w_stall_next;
        end
    end

    // Dwell counters: cycles already spent in REVERSE / in any turn state
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rev_cnt  <= '0;
            r_turn_cnt <= '0;
        end else begin
            r_rev_cnt  <= ((r_state == ST_REVERSE) && (w_next == ST_REVERSE))
                          ? r_rev_cnt + c_REV_W'(1) : '0;
            r_turn_cnt <= (w_in_turn && w_next_turn) ? r_turn_cnt + c_TURN_W'(1) : '0;
        end
    end

    // Free-running PWM counter and registered, PWM-gated bridge drives
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pwm_cnt <= '0;
            r_motor   <= c_MOT_OFF;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + PWM_W'(1);
            r_motor   <= w_pwm_on ? motor_code(r_state) : c_MOT_OFF;
        end
    end

    assign motor_a_fwd = r_motor[3];
    assign motor_a_rev = r_motor[2];
    assign motor_b_fwd = r_motor[1];
    assign motor_b_rev = r_motor[0];
    assign state_out   = r_state;
    assign stall       = r_stall;

endmodule
`default_nettype wire
